// File: rtl/p3_mem_pkg.sv
// Shared types and defaults for the p3 main-memory controller.
// Holds the FSM state encoding and the backing-store reset pattern.
package p3_mem_pkg;

  localparam int ADDR_W_DEF  = 5;
  localparam int DATA_W_DEF  = 8;
  localparam int LATENCY_DEF = 3;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    RD,
    RESP
  } state_t;

  function automatic logic [31:0] init_word(input int i);
    return 32'(i);
  endfunction

endpackage

// File: rtl/p3_mem_ctrl_wait_counter.sv
// Loadable down-counter for memory access latency.
// done is high while the count sits at zero.
module p3_wait_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/p3_mem_ctrl.sv
// Miss service stage below p3_cache: optional write-back, then a
// fixed-latency fill read returned over a valid/ready response.
module p3_mem_ctrl
  import p3_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wb,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] fill_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(LATENCY - 1);

  state_t            state;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [ADDR_W-1:0] fill_addr_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic accept;
  logic cnt_load;
  logic cnt_en;
  logic cnt_done;

  assign accept   = (state == IDLE) && req_valid && req_ready;
  assign cnt_en   = (state == WB) || (state == RD);
  // one counter serves both phases: WB reloads it on completion
  assign cnt_load = accept || ((state == WB) && cnt_done);
  assign busy     = (state != IDLE);

  p3_wait_counter #(
    .W (CNT_W)
  ) u_wait (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (RELOAD),
    .en       (cnt_en),
    .done     (cnt_done)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      fill_addr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(init_word(i));
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            wb_addr_q   <= wb_addr;
            wb_data_q   <= wb_data;
            fill_addr_q <= fill_addr;
            req_ready   <= 1'b0;
            state       <= req_wb ? WB : RD;
          end
        end
        WB: begin
          if (cnt_done) begin
            mem[wb_addr_q] <= wb_data_q;
            state          <= RD;
          end
        end
        RD: begin
          if (cnt_done) begin
            resp_data  <= mem[fill_addr_q];
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
